// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/result bundle between the EX stage and alu_muldiv.
// The master drives the request; the slave returns results and status.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic             unsig;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] aluout;
    logic             compout;
    logic             overflow;
    logic             busy;
    logic             done;
    logic             divzero;

    modport master (
        output start, op, unsig, a, b,
        input  aluout, compout, overflow, busy, done, divzero
    );

    modport slave (
        input  start, op, unsig, a, b,
        output aluout, compout, overflow, busy, done, divzero
    );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with registered results and iterative MUL/DIV.
// Build option ALU_DIVZERO_TRAP_EN: DIV by zero aborts in one cycle, divzero=1.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic         clock,
    input logic         reset,
    alu_muldiv_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_UND  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_MFHI = 4'b1100;
    localparam logic [3:0] OP_MFLO = 4'b1101;
    localparam logic [3:0] OP_MTHI = 4'b1110;
    localparam logic [3:0] OP_MTLO = 4'b1111;

    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   aluout_q, aluout_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               compout_q, compout_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               divz_q, divz_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;

    logic               sa, sb, lt, op_ok, div_trap;
    logic [WIDTH-1:0]   mag_a, mag_b, sum, dif;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_trial;
    logic [2*WIDTH-1:0] prod_fix;

    assign sa    = ~bus.unsig & bus.a[WIDTH-1];
    assign sb    = ~bus.unsig & bus.b[WIDTH-1];
    assign mag_a = sa ? -bus.a : bus.a;
    assign mag_b = sb ? -bus.b : bus.b;
    assign sum   = bus.a + bus.b;
    assign dif   = bus.a - bus.b;
    assign lt    = bus.unsig ? (bus.a < bus.b)
                             : ($signed(bus.a) < $signed(bus.b));
    assign op_ok = !(bus.op == OP_UND || bus.op == 4'b1001 ||
                     bus.op == 4'b1011);

`ifdef ALU_DIVZERO_TRAP_EN
    assign div_trap = (bus.b == '0);
`else
    assign div_trap = 1'b0;
`endif

    // acc holds {partial product, multiplier} or {remainder, quotient}
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opd_q};
    assign prod_fix  = neg_q ? -acc_q : acc_q;
    assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                              : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aluout_d  = aluout_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        opd_d     = opd_q;
        acc_d     = acc_q;
        compout_d = compout_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        divz_d    = divz_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    done_d = 1'b1;
                    if (op_ok) begin
                        compout_d = lt;
                        ovf_d     = 1'b0;
                        divz_d    = 1'b0;
                    end
                    unique case (bus.op)
                        OP_AND: aluout_d = bus.a & bus.b;
                        OP_OR:  aluout_d = bus.a | bus.b;
                        OP_NOR: aluout_d = ~(bus.a | bus.b);
                        OP_XOR: aluout_d = bus.a ^ bus.b;
                        OP_ADD: begin
                            aluout_d = sum;
                            ovf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                    (sum[WIDTH-1] != bus.a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            aluout_d = dif;
                            ovf_d = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                    (dif[WIDTH-1] != bus.a[WIDTH-1]);
                        end
                        OP_SLT: aluout_d = {{(WIDTH-1){1'b0}}, lt};
                        OP_MUL: begin
                            done_d  = 1'b0;
                            state_d = S_MUL;
                            cnt_d   = '0;
                            acc_d   = {{WIDTH{1'b0}}, mag_a};
                            opd_d   = mag_b;
                            neg_d   = sa ^ sb;
                            rneg_d  = sa;
                        end
                        OP_DIV: begin
                            if (div_trap) begin
                                divz_d = 1'b1;
                            end else begin
                                done_d  = 1'b0;
                                state_d = S_DIV;
                                cnt_d   = '0;
                                acc_d   = {{WIDTH{1'b0}}, mag_a};
                                opd_d   = mag_b;
                                neg_d   = sa ^ sb;
                                rneg_d  = sa;
                                ovf_d   = ~bus.unsig & (bus.a == MIN_V) &
                                          (&bus.b);
                            end
                        end
                        OP_MFHI: aluout_d = hi_q;
                        OP_MFLO: aluout_d = lo_q;
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == LAST) begin
                    {hi_d, lo_d} = prod_fix;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                                     : {1'b0, acc_q[2*WIDTH-1:1]};
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q == LAST) begin
                    lo_d    = quo_fix;
                    hi_d    = rem_fix;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    // borrow out of the trial subtract means restore
                    if (div_trial[WIDTH]) begin
                        acc_d = {div_shift[WIDTH-1:0],
                                 acc_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = {div_trial[WIDTH-1:0],
                                 acc_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            aluout_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            opd_q     <= '0;
            acc_q     <= '0;
            compout_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            divz_q    <= 1'b0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aluout_q  <= aluout_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            opd_q     <= opd_d;
            acc_q     <= acc_d;
            compout_q <= compout_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            divz_q    <= divz_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
        end
    end

    assign bus.aluout   = aluout_q;
    assign bus.compout  = compout_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.divzero  = divz_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: vector table, hand-written MUL/DIV sequences and random ops
// checked against a 64-bit arithmetic reference model of alu_muldiv.
module tb_alu_muldiv;
    localparam int W = 32;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_UND  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1010;
    localparam logic [3:0] OP_MFHI = 4'b1100;
    localparam logic [3:0] OP_MFLO = 4'b1101;
    localparam logic [3:0] OP_MTHI = 4'b1110;
    localparam logic [3:0] OP_MTLO = 4'b1111;
    localparam logic [W-1:0] MIN_V = 32'h8000_0000;
    localparam int NV = 13;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    alu_muldiv_if #(.WIDTH(W)) bus ();
    alu_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] m_alu, m_hi, m_lo;
    logic         m_cmp, m_ovf, m_dz;
    int           m_cyc;

    typedef struct {
        logic [3:0]   op;
        logic         u;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] alu;
        logic         cmp;
        logic         ovf;
    } vec_t;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_alu = '0; m_hi = '0; m_lo = '0;
        m_cmp = 1'b0; m_ovf = 1'b0; m_dz = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] op, input logic u,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        longint xa, xb, sa, sb, s, q, r;
        logic [63:0] p;
        logic lt;
        xa = u ? longint'({32'h0, a}) : longint'($signed(a));
        xb = u ? longint'({32'h0, b}) : longint'($signed(b));
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lt = (xa < xb);
        m_cyc = 0;
        if (!(op == OP_UND || op == 4'b1001 || op == 4'b1011)) begin
            m_cmp = lt; m_ovf = 1'b0; m_dz = 1'b0;
        end
        case (op)
            OP_AND: m_alu = a & b;
            OP_OR:  m_alu = a | b;
            OP_NOR: m_alu = ~(a | b);
            OP_XOR: m_alu = a ^ b;
            OP_ADD: begin
                m_alu = a + b;
                s = sa + sb;
                m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                m_alu = a - b;
                s = sa - sb;
                m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SLT: m_alu = {31'b0, lt};
            OP_MUL: begin
                p = 64'(xa * xb);
                m_hi = p[63:32]; m_lo = p[31:0];
                m_cyc = W + 1;
            end
            OP_DIV: begin
                if (b == 0) begin
`ifdef ALU_DIVZERO_TRAP_EN
                    m_dz = 1'b1;
`else
                    m_cyc = W + 1;
                    m_hi = a;
                    m_lo = (!u && a[W-1]) ? 32'h1 : 32'hFFFF_FFFF;
`endif
                end else begin
                    q = xa / xb;
                    r = xa % xb;
                    m_lo = q[31:0]; m_hi = r[31:0];
                    m_cyc = W + 1;
                    m_ovf = !u && (a == MIN_V) && (b == 32'hFFFF_FFFF);
                end
            end
            OP_MFHI: m_alu = m_hi;
            OP_MFLO: m_alu = m_lo;
            OP_MTHI: m_hi = a;
            OP_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic drive(input logic [3:0] op, input logic u,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.op = op; bus.unsig = u;
        bus.a = a; bus.b = b;
    endtask

    task automatic run_op(input logic [3:0] op, input logic u,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic b2b);
        int nb;
        model_step(op, u, a, b);
        if (!b2b) @(negedge clock);
        drive(op, u, a, b);
        @(negedge clock);
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        nb = 0;
        while (bus.busy && nb < 100) begin
            nb++;
            @(negedge clock);
        end
        chk("busy_cycles", 64'(nb), 64'(m_cyc));
        chk("done", 64'(bus.done), 64'd1);
        chk("aluout", 64'(bus.aluout), 64'(m_alu));
        chk("compout", 64'(bus.compout), 64'(m_cmp));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("divzero", 64'(bus.divzero), 64'(m_dz));
    endtask

    logic [3:0] rops [14];
    logic [W-1:0] ra, rb, exp_hi, exp_lo;
    logic [3:0] rop;
    int nb, nd;

    initial begin
        vecs[0]  = '{OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[1]  = '{OP_SUB, 1'b0, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[2]  = '{OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b1, 1'b0};
        vecs[3]  = '{OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0};
        vecs[4]  = '{OP_AND, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, 1'b0};
        vecs[5]  = '{OP_OR,  1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6]  = '{OP_NOR, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7]  = '{OP_XOR, 1'b1, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678, 1'b1, 1'b0};
        vecs[8]  = '{OP_ADD, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{OP_SUB, 1'b0, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[10] = '{OP_UND, 1'b0, 32'h1, 32'h2, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[11] = '{OP_ADD, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{OP_SLT, 1'b0, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0};
        rops = '{OP_AND, OP_OR, OP_ADD, OP_NOR, OP_XOR, OP_SUB, OP_SLT,
                 OP_MUL, OP_DIV, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_UND};

        bus.start = 1'b0; bus.op = '0; bus.unsig = 1'b0;
        bus.a = '0; bus.b = '0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_aluout", 64'(bus.aluout), 64'd0);
        chk("rst_flags", {59'd0, bus.compout, bus.overflow, bus.busy,
                          bus.done, bus.divzero}, 64'd0);
        reset = 1'b0;
        model_reset();
        run_op(OP_MFHI, 1'b0, 0, 0, 1'b0);
        run_op(OP_MFLO, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].u, vecs[i].a, vecs[i].b, 1'b0);
            chk("vec_alu", 64'(bus.aluout), 64'(vecs[i].alu));
            chk("vec_cmp", 64'(bus.compout), 64'(vecs[i].cmp));
            chk("vec_ovf", 64'(bus.overflow), 64'(vecs[i].ovf));
        end

        // MUL results read back in the very cycle done is high
        run_op(OP_MUL, 1'b0, -32'sd3, 32'd7, 1'b0);
        run_op(OP_MFHI, 1'b0, 0, 0, 1'b1);
        chk("mul_s_hi", 64'(bus.aluout), 64'hFFFF_FFFF);
        run_op(OP_MFLO, 1'b0, 0, 0, 1'b0);
        chk("mul_s_lo", 64'(bus.aluout), 64'hFFFF_FFEB);
        run_op(OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op(OP_MFHI, 1'b0, 0, 0, 1'b1);
        chk("mul_u_hi", 64'(bus.aluout), 64'h1);
        run_op(OP_MFLO, 1'b0, 0, 0, 1'b0);
        chk("mul_u_lo", 64'(bus.aluout), 64'hFFFF_FFFE);

        // DIV with a second start injected while busy
        model_step(OP_DIV, 1'b0, -32'sd7, 32'd2);
        @(negedge clock);
        drive(OP_DIV, 1'b0, -32'sd7, 32'd2);
        @(negedge clock);
        bus.start = 1'b0;
        nb = 0; nd = 0;
        while (bus.busy && nb < 100) begin
            if (bus.done) nd++;
            if (nb == 5) drive(OP_ADD, 1'b0, 32'd1, 32'd1);
            else bus.start = 1'b0;
            nb++;
            @(negedge clock);
        end
        bus.start = 1'b0;
        if (bus.done) nd++;
        chk("div_busy", 64'(nb), 64'(W + 1));
        chk("div_aluout_hold", 64'(bus.aluout), 64'(m_alu));
        chk("div_cmp", 64'(bus.compout), 64'd1);
        @(negedge clock);
        if (bus.done) nd++;
        chk("div_done_count", 64'(nd), 64'd1);
        run_op(OP_MFLO, 1'b0, 0, 0, 1'b1);
        chk("div_lo", 64'(bus.aluout), 64'hFFFF_FFFD);
        run_op(OP_MFHI, 1'b0, 0, 0, 1'b0);
        chk("div_hi", 64'(bus.aluout), 64'hFFFF_FFFF);

        run_op(OP_DIV, 1'b0, MIN_V, 32'hFFFF_FFFF, 1'b0);
        chk("div_min_ovf", 64'(bus.overflow), 64'd1);
        run_op(OP_MFLO, 1'b0, 0, 0, 1'b1);
        chk("div_min_lo", 64'(bus.aluout), 64'h8000_0000);
        run_op(OP_MFHI, 1'b0, 0, 0, 1'b0);
        chk("div_min_hi", 64'(bus.aluout), 64'h0);

        // reset lands mid-division
        @(negedge clock);
        drive(OP_DIV, 1'b1, 32'd1000, 32'd7);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_alu", 64'(bus.aluout), 64'd0);
        model_reset();
        run_op(OP_MFHI, 1'b0, 0, 0, 1'b1);
        run_op(OP_MFLO, 1'b0, 0, 0, 1'b0);
        run_op(OP_ADD, 1'b0, 32'd2, 32'd3, 1'b0);
        chk("post_rst_add", 64'(bus.aluout), 64'd5);

        // division by zero with known HI/LO beforehand
        run_op(OP_MTHI, 1'b0, 32'h1111_2222, 0, 1'b0);
        run_op(OP_MTLO, 1'b0, 32'h3333_4444, 0, 1'b0);
        run_op(OP_DIV, 1'b1, 32'd5, 32'd0, 1'b0);
`ifdef ALU_DIVZERO_TRAP_EN
        chk("dz_flag", 64'(bus.divzero), 64'd1);
        exp_hi = 32'h1111_2222; exp_lo = 32'h3333_4444;
`else
        chk("dz_flag", 64'(bus.divzero), 64'd0);
        exp_hi = 32'd5; exp_lo = 32'hFFFF_FFFF;
`endif
        run_op(OP_MFHI, 1'b0, 0, 0, 1'b1);
        chk("dz_hi", 64'(bus.aluout), 64'(exp_hi));
        run_op(OP_MFLO, 1'b0, 0, 0, 1'b0);
        chk("dz_lo", 64'(bus.aluout), 64'(exp_lo));
        chk("dz_clear", 64'(bus.divzero), 64'd0);

        for (int i = 0; i < 150; i++) begin
            rop = rops[$urandom_range(0, 13)];
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = MIN_V;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h7FFF_FFFF;
                default: ;
            endcase
            if (rop == OP_DIV && rb == 0) rb = 32'd1;
            run_op(rop, 1'($urandom_range(0, 1)), ra, rb,
                   1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
